// File: rtl/ir_receiver_sm.sv
// IR packet decoder: measures burst/gap runs of the filtered IR envelope in carrier periods
// and validates Start, CarSelect and the four direction fields into a 4-bit command.
module ir_receiver_sm #(
   parameter int CLKS_PER_PULSE = 2777,
   parameter int DEBOUNCE       = 16,
   parameter int START_MIN      = 150,
   parameter int START_MAX      = 230,
   parameter int SEL_MIN        = 38,
   parameter int SEL_MAX        = 56,
   parameter int DEA_MIN        = 16,
   parameter int DEA_MAX        = 30,
   parameter int GAP_MIN        = 18,
   parameter int GAP_MAX        = 32
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       IR_IN,
   output logic [3:0] COMMAND,
   output logic       PACKET_VALID,
   output logic       PACKET_ERROR,
   output logic       BUSY
);
   // state | meaning
   // IDLE  | waiting for a rise of the filtered envelope
   // START | measuring the Start burst
   // GAP   | measuring a gap; field holds the burst that follows
   // BURST | measuring the CarSelect or a direction burst
   // TAIL  | gap after Forward; completes once GAP_MIN pulses have elapsed
   // DONE  | one cycle with PACKET_VALID high
   typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_BURST, S_TAIL, S_DONE} state_t;

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);
   localparam logic [11:0]     DIV_LAST = 12'(CLKS_PER_PULSE - 1);
   localparam logic [7:0] START_MIN_R = 8'(START_MIN);
   localparam logic [7:0] START_MAX_R = 8'(START_MAX);
   localparam logic [7:0] SEL_MIN_R   = 8'(SEL_MIN);
   localparam logic [7:0] SEL_MAX_R   = 8'(SEL_MAX);
   localparam logic [7:0] DEA_MIN_R   = 8'(DEA_MIN);
   localparam logic [7:0] DEA_MAX_R   = 8'(DEA_MAX);
   localparam logic [7:0] GAP_MIN_R   = 8'(GAP_MIN);
   localparam logic [7:0] GAP_MAX_R   = 8'(GAP_MAX);
   localparam logic [2:0] F_SEL = 3'd0;
   localparam logic [2:0] F_F   = 3'd4;

   logic            sync_1, sync_2, lvl, lvl_d;
   logic [DB_W-1:0] db_cnt;
   logic [11:0]     div;
   logic [7:0]      run;
   state_t          state;
   logic [2:0]      field;
   logic [3:0]      shift;
   logic            err_hit;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         lvl    <= 1'b0;
         lvl_d  <= 1'b0;
         db_cnt <= '0;
      end else begin
         sync_1 <= IR_IN;
         sync_2 <= sync_1;
         lvl_d  <= lvl;
         if (sync_2 == lvl) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            lvl    <= sync_2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   logic lvl_edge, lvl_rise, lvl_fall;
   assign lvl_edge = lvl ^ lvl_d;
   assign lvl_rise = lvl & ~lvl_d;
   assign lvl_fall = ~lvl & lvl_d;

   // An edge takes priority over a divider wrap in the same cycle.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         div <= '0;
         run <= '0;
      end else if (lvl_edge) begin
         div <= '0;
         run <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         if (run != 8'hFF) run <= run + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   logic in_start, in_sel, in_dea, in_gap;
   assign in_start = (run >= START_MIN_R) && (run <= START_MAX_R);
   assign in_sel   = (run >= SEL_MIN_R)   && (run <= SEL_MAX_R);
   assign in_dea   = (run >= DEA_MIN_R)   && (run <= DEA_MAX_R);
   assign in_gap   = (run >= GAP_MIN_R)   && (run <= GAP_MAX_R);

   always_comb begin
      err_hit = 1'b0;
      case (state)
         S_GAP:   err_hit = lvl_rise ? !in_gap : (run > GAP_MAX_R);
         S_BURST: begin
            if (lvl_fall)
               err_hit = (field == F_SEL) ? !in_sel : !(in_sel || in_dea);
            else
               err_hit = (field != F_SEL) && (run > SEL_MAX_R);
         end
         S_TAIL:  err_hit = lvl_rise;
         default: err_hit = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state        <= S_IDLE;
         field        <= F_SEL;
         shift        <= '0;
         COMMAND      <= '0;
         PACKET_VALID <= 1'b0;
         PACKET_ERROR <= 1'b0;
         BUSY         <= 1'b0;
      end else begin
         PACKET_VALID <= 1'b0;
         PACKET_ERROR <= 1'b0;
         if (err_hit) begin
            state        <= S_IDLE;
            shift        <= '0;
            PACKET_ERROR <= 1'b1;
            BUSY         <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (lvl_rise) begin
                     state <= S_START;
                     BUSY  <= 1'b1;
                  end
               end
               S_START: begin
                  // Out-of-window or stuck-high starts are treated as noise.
                  if (lvl_fall && in_start) begin
                     state <= S_GAP;
                     field <= F_SEL;
                  end else if (lvl_fall || (run > START_MAX_R)) begin
                     state <= S_IDLE;
                     BUSY  <= 1'b0;
                  end
               end
               S_GAP: begin
                  if (lvl_rise) state <= S_BURST;
               end
               S_BURST: begin
                  if (lvl_fall) begin
                     if (field != F_SEL) shift <= {shift[2:0], in_sel};
                     if (field == F_F) begin
                        state <= S_TAIL;
                     end else begin
                        state <= S_GAP;
                        field <= field + 3'd1;
                     end
                  end
               end
               S_TAIL: begin
                  if (run >= GAP_MIN_R) begin
                     state        <= S_DONE;
                     COMMAND      <= shift;
                     PACKET_VALID <= 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/ir_receiver_sm.md
Name: ir_receiver_sm

Overview:
- IR packet decoder for the blue-coded car; the receive end of the burst/gap packet protocol our IR transmitter emits.
- Takes the demodulated IR envelope from the on-car receiver module. Measures burst and gap lengths in 36 kHz carrier periods.
- Validates the packet structure Start, Gap, CarSelect, Gap, then Right, Left, Backward, Forward, each followed by a Gap.
- Presents the decoded 4-bit command with one-cycle valid and error strobes to the bus/peripheral logic.

Parameters:
- CLKS_PER_PULSE, 2777: CLK cycles per carrier period (100 MHz / 36 kHz, truncated).
- DEBOUNCE, 16: CLK cycles the synchronized input must be stable before a level change is accepted.
- START_MIN, 150 / START_MAX, 230: accepted Start burst length, in pulses (nominal 191).
- SEL_MIN, 38 / SEL_MAX, 56: accepted CarSelect and asserted-direction burst length (nominal 47).
- DEA_MIN, 16 / DEA_MAX, 30: accepted de-asserted-direction burst length (nominal 22).
- GAP_MIN, 18 / GAP_MAX, 32: accepted gap length (nominal 25).

Ports:
- CLK  in  1  100 MHz system clock
- RESETN  in  1  asynchronous active-low reset
- IR_IN  in  1  asynchronous demodulated envelope; 1 = carrier present
- COMMAND  out  4  last valid command: [3] right, [2] left, [1] back, [0] forward
- PACKET_VALID  out  1  one-cycle pulse; COMMAND updated in the same cycle
- PACKET_ERROR  out  1  one-cycle pulse on malformed packet after a valid Start
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset and clocking:
  - Reset is RESETN, asynchronous, active-low; clock is CLK.
  - All outputs reset to 0; state resets to IDLE; all counters reset to 0.
- Input path:
  - IR_IN goes through a 2-flop synchronizer, then a DEBOUNCE filter. The filtered level `lvl` changes only after DEBOUNCE consecutive equal samples.
  - A rise or fall of `lvl` is an edge.
- Run measurement:
  - On every edge, the divider (12 bit) and the pulse counter `run` (8 bit) clear.
  - The divider counts CLK cycles and wraps at CLKS_PER_PULSE-1. `run` increments on each wrap and saturates at 255.
  - Run length = `run` value at the terminating edge.
- States and transitions:
  - IDLE: rise -> START.
  - START: fall with run in [START_MIN,START_MAX] -> GAP, field=SEL.
    - Fall out of window -> IDLE, no error (noise rejection).
    - run > START_MAX while high -> IDLE, no error; IDLE needs a rise, so a stuck-high input cannot retrigger.
  - GAP: rise with run in [GAP_MIN,GAP_MAX] -> BURST.
    - Rise with run < GAP_MIN -> error.
    - run reaches GAP_MAX+1 while low -> error (timeout).
  - BURST, field SEL: fall with run in [SEL_MIN,SEL_MAX] -> GAP, field=R; otherwise error.
  - BURST, field R/L/B/F:
    - Run in [SEL_MIN,SEL_MAX] captures bit 1; run in [DEA_MIN,DEA_MAX] captures bit 0; otherwise error.
    - run exceeding SEL_MAX while high -> error immediately.
    - Capture order is shift register bits 3,2,1,0. After field F -> TAIL; otherwise -> GAP with the next field.
  - TAIL: run reaches GAP_MIN while low -> DONE. A rise first -> error.
  - DONE (one cycle): COMMAND <= shift register; PACKET_VALID=1; -> IDLE.
  - error: PACKET_ERROR=1 for one cycle; COMMAND unchanged; shift register cleared; -> IDLE.
- Latency and strobes:
  - PACKET_VALID asserts GAP_MIN pulses (+2 sync +DEBOUNCE cycles) after the physical fall of the Forward burst.
  - PACKET_VALID and PACKET_ERROR are never high together.
- Boundary conditions:
  - COMMAND holds its value across errors and idle periods; it changes only in DONE.
  - An edge arriving in the same cycle as a divider wrap: the edge wins, and `run` clears.
  - RESETN asserted mid-packet: immediate return to IDLE and all outputs 0. The partial packet is discarded; no strobe fires after release.
  - A new Start arriving while in GAP/BURST is not special-cased; it is judged against the current field's window and normally produces an error.

Test Plan:
1. Nominal packet (191/25/47/25, then R=47, L=22, B=47, F=22 with 25 gaps) -> COMMAND=4'b1010, one PACKET_VALID pulse 18 pulses (+18 cycles) after the last fall, BUSY low next cycle.
2. Packet with all directions 22 pulses, then one with all 47 pulses -> COMMAND=4'b0000, then 4'b1111; two VALID pulses, no ERROR.
3. Left burst of 34 pulses -> one PACKET_ERROR at the fall, no VALID, COMMAND keeps previous value; a following nominal packet decodes correctly.
4. Gap after CarSelect held low for 60 pulses -> PACKET_ERROR when run reaches 33, state IDLE, BUSY=0.
5. Noise handling: 5-pulse burst in IDLE -> no strobes. 8-cycle glitch on IR_IN mid-burst -> filtered out, packet still VALID.
6. RESETN pulsed low during the Backward burst -> outputs 0 immediately, no strobes afterwards; the next nominal packet yields VALID with the correct COMMAND.
